cia_timer_bank: RTL and testbench

- Parametrised CIA-style interval timer bank: CHANNELS independent down-counters of width W, each with a latch, a control register, one-shot or continuous run, and a PB-style output pin.
- Channel c can be cascaded from channel c-1.
- A shared ICR/IMR interrupt unit with CIA semantics: mask set/clear on write, read-to-clear.
- Sits on the 6502 bus beside the I/O chips, clocked by clk with phi2_p/phi2_n strobes.

---
 rtl/cia_timer_pkg.sv | 39 +++
 rtl/cia_timer_chan.sv | 147 ++++++++++++++
 rtl/cia_timer_bank.sv | 122 ++++++++++++
 tb/tb_cia_timer_bank.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_timer_pkg.sv
// Shared definitions for the CIA-style timer bank.
// CTRL register bit positions, the INMODE tick-source encoding, and
// helpers that place the ICR and split a bus address into (channel, byte).
package cia_timer_pkg;

   localparam int CTRL_START  = 0;
   localparam int CTRL_OUTEN  = 1;
   localparam int CTRL_TOGGLE = 2;
   localparam int CTRL_ONESHOT = 3;
   localparam int CTRL_LOAD   = 4;
   localparam int CTRL_INMODE = 5;

   localparam int REGS_PER_CHAN = 4;
   localparam logic [1:0] K_CTRL = 2'd3;

   typedef enum logic [1:0] {
      INMODE_PHI2          = 2'b00,
      INMODE_CNT           = 2'b01,
      INMODE_CASCADE       = 2'b10,
      INMODE_CASCADE_GATED = 2'b11
   } inmode_e;

   typedef struct packed {
      logic [5:0] chan;
      logic [1:0] k;
   } reg_sel_t;

   function automatic int icr_offset(input int channels);
      return channels * REGS_PER_CHAN;
   endfunction

   function automatic reg_sel_t decode_addr(input logic [7:0] a);
      reg_sel_t s;
      s.chan = a[7:2];
      s.k    = a[1:0];
      return s;
   endfunction

endpackage

// File: rtl/cia_timer_chan.sv
// One timer channel: down-counter, reload latch, read snapshot, CTRL and
// the PB-style output pin.
// Ports: clk/res; phi2_p count strobe; rd/wr already qualified for this
// channel with byte index k and db_in; cnt_lvl/cnt_rise from the shared
// CNT sampler; uf_in from the previous channel; uf_out underflow strobe
// (combinational, feeds the next channel in the same phi2_p); rd_byte read
// data for the selected byte; tmr_out output pin.
module cia_timer_chan
   import cia_timer_pkg::*;
#(
   parameter int W = 16
) (
   input  logic       clk,
   input  logic       res,
   input  logic       phi2_p,
   input  logic       rd,
   input  logic       wr,
   input  logic [1:0] k,
   input  logic [7:0] db_in,
   input  logic       cnt_lvl,
   input  logic       cnt_rise,
   input  logic       uf_in,
   output logic       uf_out,
   output logic [7:0] rd_byte,
   output logic       tmr_out
);
   localparam int NB = W / 8;
   localparam logic [1:0] K_TOP = 2'(NB - 1);
   // Byte 0 is always read live, so only the upper bytes are captured.
   localparam int SW = (W > 8) ? W - 8 : 1;

   logic [W-1:0]  cnt_q, cnt_d, latch_q, latch_d;
   logic [SW-1:0] snap_q, snap_d;
   logic          snap_vld_q, snap_vld_d;
   logic          start_q, start_d, outen_q, outen_d, toggle_q, toggle_d;
   logic          oneshot_q, oneshot_d, load_pend_q, load_pend_d, out_q, out_d;
   inmode_e       inmode_q, inmode_d;
   logic          src, tick, uf, wr_ctrl;

   assign wr_ctrl = wr && (k == K_CTRL);

   always_comb begin
      src = 1'b0;
      case (inmode_q)
         INMODE_PHI2:          src = 1'b1;
         INMODE_CNT:           src = cnt_rise;
         INMODE_CASCADE:       src = uf_in;
         INMODE_CASCADE_GATED: src = uf_in & cnt_lvl;
         default:              src = 1'b0;
      endcase
      // A pending LOAD owns this phi2_p; no tick, no underflow.
      tick = phi2_p & start_q & src & ~load_pend_q;
      uf   = tick & (cnt_q == '0);
   end

   always_comb begin
      latch_d = latch_q;
      for (int b = 0; b < NB; b++)
         if (wr && (k == 2'(b))) latch_d[8*b +: 8] = db_in;

      cnt_d = cnt_q;
      if (phi2_p && load_pend_q)
         cnt_d = latch_d;
      else if (tick)
         cnt_d = uf ? latch_d : cnt_q - W'(1);
      if (wr && (k == K_TOP) && !start_q)
         cnt_d = latch_d;

      load_pend_d = phi2_p ? 1'b0 : load_pend_q;
      if (wr_ctrl && db_in[CTRL_LOAD]) load_pend_d = 1'b1;

      start_d   = start_q;
      outen_d   = outen_q;
      toggle_d  = toggle_q;
      oneshot_d = oneshot_q;
      inmode_d  = inmode_q;
      if (uf && oneshot_q) start_d = 1'b0;
      if (wr_ctrl) begin
         start_d   = db_in[CTRL_START];
         outen_d   = db_in[CTRL_OUTEN];
         toggle_d  = db_in[CTRL_TOGGLE];
         oneshot_d = db_in[CTRL_ONESHOT];
         inmode_d  = inmode_e'(db_in[CTRL_INMODE +: 2]);
      end

      out_d = out_q;
      if (phi2_p) begin
         if (!outen_q)      out_d = 1'b1;
         else if (toggle_q) out_d = out_q ^ uf;
         else               out_d = ~uf;
      end
      if (wr_ctrl && !start_q && db_in[CTRL_START] && db_in[CTRL_TOGGLE])
         out_d = 1'b1;

      snap_d     = snap_q;
      snap_vld_d = snap_vld_q;
      if (rd && (k == 2'd0)) begin
         snap_d     = cnt_q[W-1 -: SW];
         snap_vld_d = 1'b1;
      end
   end

   // Until the first byte-0 read the snapshot simply mirrors the counter.
   always_comb begin
      rd_byte = '0;
      if (k == K_CTRL)
         rd_byte = {1'b0, inmode_q, 1'b0, oneshot_q, toggle_q, outen_q, start_q};
      else if (k == 2'd0)
         rd_byte = cnt_q[7:0];
      else
         for (int b = 1; b < NB; b++)
            if (k == 2'(b))
               rd_byte = snap_vld_q ? snap_q[8*(b-1) +: 8] : cnt_q[8*b +: 8];
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt_q       <= '0;
         latch_q     <= '1;
         snap_q      <= '0;
         snap_vld_q  <= 1'b0;
         start_q     <= 1'b0;
         outen_q     <= 1'b0;
         toggle_q    <= 1'b0;
         oneshot_q   <= 1'b0;
         inmode_q    <= INMODE_PHI2;
         load_pend_q <= 1'b0;
         out_q       <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         latch_q     <= latch_d;
         snap_q      <= snap_d;
         snap_vld_q  <= snap_vld_d;
         start_q     <= start_d;
         outen_q     <= outen_d;
         toggle_q    <= toggle_d;
         oneshot_q   <= oneshot_d;
         inmode_q    <= inmode_d;
         load_pend_q <= load_pend_d;
         out_q       <= out_d;
      end
   end

   assign uf_out  = uf;
   assign tmr_out = out_q;

endmodule

// File: rtl/cia_timer_bank.sv
// CIA-style interval timer bank on the 6502 bus.
// Ports: clk, res (async, active high); phi2_p count strobe; phi2_n bus
// strobe; cs_n/rw/addr/db_in bus inputs; db_out registered read data;
// cnt_in external CNT pin; tmr_out per-channel output pins; irq_n
// active-low interrupt. Holds bus decode, CNT sampling, ICR/IMR and the
// read mux; the channels are chained so underflows cascade in one phi2_p.
module cia_timer_bank
   import cia_timer_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int W        = 16,
   parameter int ADDR_W   = 5
) (
   input  logic                clk,
   input  logic                res,
   input  logic                phi2_p,
   input  logic                phi2_n,
   input  logic                cs_n,
   input  logic                rw,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [7:0]          db_in,
   output logic [7:0]          db_out,
   input  logic                cnt_in,
   output logic [CHANNELS-1:0] tmr_out,
   output logic                irq_n
);
   localparam logic [7:0] ICR_ADDR = 8'(icr_offset(CHANNELS));

   logic                rd, wr, is_icr;
   reg_sel_t            sel;
   logic [CHANNELS:0]   uf_chain;
   logic [CHANNELS-1:0] uf;
   logic [7:0]          chan_rd [CHANNELS];
   logic [7:0]          rd_mux;

   logic                cnt_prev_q, cnt_prev_d;
   logic [CHANNELS-1:0] flags_q, flags_d, imr_q, imr_d;
   logic                irq_q, irq_d, clr_pend_q, clr_pend_d;
   logic [7:0]          db_out_q, db_out_d;

   assign rd     = phi2_n & ~cs_n & rw;
   assign wr     = phi2_n & ~cs_n & ~rw;
   assign sel    = decode_addr(8'(addr));
   assign is_icr = (8'(addr) == ICR_ADDR);

   assign uf_chain[0] = 1'b0;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      cia_timer_chan #(.W(W)) u_chan (
         .clk      (clk),
         .res      (res),
         .phi2_p   (phi2_p),
         .rd       (rd && (sel.chan == 6'(c))),
         .wr       (wr && (sel.chan == 6'(c))),
         .k        (sel.k),
         .db_in    (db_in),
         .cnt_lvl  (cnt_in),
         .cnt_rise (cnt_in & ~cnt_prev_q),
         .uf_in    (uf_chain[c]),
         .uf_out   (uf_chain[c+1]),
         .rd_byte  (chan_rd[c]),
         .tmr_out  (tmr_out[c])
      );
   end

   assign uf = uf_chain[CHANNELS:1];

   always_comb begin
      rd_mux = '0;
      if (is_icr)
         rd_mux = {irq_q, {(7-CHANNELS){1'b0}}, flags_q};
      else
         for (int c = 0; c < CHANNELS; c++)
            if (sel.chan == 6'(c)) rd_mux = chan_rd[c];
   end

   always_comb begin
      cnt_prev_d = phi2_p ? cnt_in : cnt_prev_q;

      imr_d = imr_q;
      if (wr && is_icr)
         imr_d = db_in[7] ? (imr_q | db_in[CHANNELS-1:0])
                          : (imr_q & ~db_in[CHANNELS-1:0]);

      // An underflow arriving together with the clearing read keeps its flag.
      flags_d = flags_q;
      if (rd && is_icr) flags_d = '0;
      flags_d = flags_d | uf;

      // irq release is deferred to the next phi2_p after an ICR read.
      clr_pend_d = phi2_p ? 1'b0 : clr_pend_q;
      if (rd && is_icr) clr_pend_d = 1'b1;

      irq_d = irq_q;
      if (phi2_p)
         irq_d = clr_pend_q ? 1'b0 : (irq_q | (|(imr_q & flags_q)));

      db_out_d = rd ? rd_mux : db_out_q;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         cnt_prev_q <= 1'b0;
         flags_q    <= '0;
         imr_q      <= '0;
         irq_q      <= 1'b0;
         clr_pend_q <= 1'b0;
         db_out_q   <= '0;
      end else begin
         cnt_prev_q <= cnt_prev_d;
         flags_q    <= flags_d;
         imr_q      <= imr_d;
         irq_q      <= irq_d;
         clr_pend_q <= clr_pend_d;
         db_out_q   <= db_out_d;
      end
   end

   assign db_out = db_out_q;
   assign irq_n  = ~irq_q;

endmodule

// File: tb/tb_cia_timer_bank.sv
module tb_cia_timer_bank;
   localparam int CH  = 2;
   localparam int ICR = 8;

   logic          clk = 1'b0;
   logic          res, phi2_p, phi2_n, cs_n, rw, cnt_in, irq_n;
   logic [4:0]    addr;
   logic [7:0]    db_in, db_out;
   logic [CH-1:0] tmr_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cia_timer_bank dut (
      .clk(clk), .res(res), .phi2_p(phi2_p), .phi2_n(phi2_n), .cs_n(cs_n),
      .rw(rw), .addr(addr), .db_in(db_in), .db_out(db_out), .cnt_in(cnt_in),
      .tmr_out(tmr_out), .irq_n(irq_n)
   );

   // reference model state, one entry per channel
   int m_cnt [CH], m_latch [CH], m_snap [CH], m_inm [CH];
   bit m_snapv [CH], m_start [CH], m_outen [CH], m_tog [CH], m_os [CH];
   bit m_lpend [CH], m_out [CH];
   int m_flags, m_imr;
   bit m_irq, m_clr, m_cprev;
   bit cnt_drive;
   logic [7:0] rd_val;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = 0; m_latch[c] = 'hFFFF; m_snap[c] = 0; m_inm[c] = 0;
         m_snapv[c] = 0; m_start[c] = 0; m_outen[c] = 0; m_tog[c] = 0;
         m_os[c] = 0; m_lpend[c] = 0; m_out[c] = 1;
      end
      m_flags = 0; m_imr = 0; m_irq = 0; m_clr = 0; m_cprev = 0;
   endfunction

   function automatic void model_p(input bit cin);
      bit rise = cin && !m_cprev;
      bit nirq;
      bit prev_uf = 0;
      m_cprev = cin;
      nirq = m_clr ? 1'b0 : (m_irq || ((m_imr & m_flags) != 0));
      m_clr = 0;
      for (int c = 0; c < CH; c++) begin
         bit src;
         bit uf = 0;
         case (m_inm[c])
            0:       src = 1;
            1:       src = rise;
            2:       src = prev_uf;
            default: src = prev_uf && cin;
         endcase
         if (m_lpend[c]) begin
            m_cnt[c] = m_latch[c];
            m_lpend[c] = 0;
         end else if (m_start[c] && src) begin
            if (m_cnt[c] == 0) begin
               uf = 1;
               m_cnt[c] = m_latch[c];
               if (m_os[c]) m_start[c] = 0;
            end else begin
               m_cnt[c] = m_cnt[c] - 1;
            end
         end
         if (!m_outen[c])   m_out[c] = 1;
         else if (m_tog[c]) m_out[c] = m_out[c] ^ uf;
         else               m_out[c] = !uf;
         if (uf) m_flags = m_flags | (1 << c);
         prev_uf = uf;
      end
      m_irq = nirq;
   endfunction

   function automatic int model_n(input bit r, input int a, input int d);
      int v = 0;
      int c = a / 4;
      int k = a % 4;
      int msk = (1 << CH) - 1;
      if (a == ICR) begin
         if (r) begin
            v = (int'(m_irq) << 7) | m_flags;
            m_flags = 0;
            m_clr = 1;
         end else if (d[7]) m_imr = m_imr | (d & msk);
         else               m_imr = m_imr & ~(d & msk);
      end else if (c < CH) begin
         if (r) begin
            if (k == 0) begin
               v = m_cnt[c] & 'hFF;
               m_snap[c] = m_cnt[c];
               m_snapv[c] = 1;
            end else if (k == 1) begin
               v = ((m_snapv[c] ? m_snap[c] : m_cnt[c]) >> 8) & 'hFF;
            end else if (k == 3) begin
               v = int'(m_start[c]) | (int'(m_outen[c]) << 1) | (int'(m_tog[c]) << 2)
                 | (int'(m_os[c]) << 3) | (m_inm[c] << 5);
            end
         end else begin
            if (k == 0) begin
               m_latch[c] = (m_latch[c] & 'hFF00) | d;
            end else if (k == 1) begin
               m_latch[c] = (m_latch[c] & 'hFF) | (d << 8);
               if (!m_start[c]) m_cnt[c] = m_latch[c];
            end else if (k == 3) begin
               if (!m_start[c] && d[0] && d[2]) m_out[c] = 1;
               m_start[c] = d[0]; m_outen[c] = d[1]; m_tog[c] = d[2];
               m_os[c] = d[3]; m_inm[c] = (d >> 5) & 3;
               if (d[4]) m_lpend[c] = 1;
            end
         end
      end
      return v;
   endfunction

   function automatic int model_tmr();
      int o = 0;
      for (int c = 0; c < CH; c++) if (m_out[c]) o = o | (1 << c);
      return o;
   endfunction

   // One phi2 period = 4 clk: phi2_p strobe, gap, phi2_n strobe (bus), gap.
   task automatic cyc(input bit acc, input bit r, input int a, input int d);
      int exp;
      @(negedge clk);
      cnt_in = cnt_drive; phi2_p = 1'b1;
      model_p(cnt_drive);
      @(negedge clk);
      phi2_p = 1'b0;
      @(negedge clk);
      phi2_n = 1'b1;
      if (acc) begin
         cs_n = 1'b0; rw = r; addr = 5'(a); db_in = 8'(d);
      end
      @(negedge clk);
      phi2_n = 1'b0; cs_n = 1'b1; rw = 1'b1;
      if (acc) begin
         exp = model_n(r, a, d);
         if (r) begin
            rd_val = db_out;
            check($sformatf("rd_addr%0d", a), db_out, exp);
         end
      end
      check("tmr_out", tmr_out, model_tmr());
      check("irq_n", irq_n, !m_irq);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
   endtask

   task automatic bus_wr(input int a, input int d);
      cyc(1, 0, a, d);
   endtask

   task automatic bus_rd(input int a);
      cyc(1, 1, a, 0);
   endtask

   task automatic do_reset();
      res = 1'b1;
      @(negedge clk);
      @(negedge clk);
      res = 1'b0;
      model_reset();
   endtask

   initial begin
      res = 1'b1; phi2_p = 1'b0; phi2_n = 1'b0; cs_n = 1'b1; rw = 1'b1;
      addr = '0; db_in = '0; cnt_in = 1'b0; cnt_drive = 1'b0;
      model_reset();

      // reset state
      do_reset();
      check("rst_db_out", db_out, 8'h00);
      check("rst_tmr", tmr_out, 2'b11);
      check("rst_irq", irq_n, 1'b1);

      // continuous, phi2 source, period latch+1
      do_reset();
      bus_wr(0, 3); bus_wr(1, 0); bus_wr(3, 8'h01);
      idle(2);
      bus_rd(ICR); check("t1_early", rd_val, 8'h00);
      bus_rd(ICR); check("t1_uf", rd_val, 8'h01);
      bus_rd(ICR); check("t1_clr", rd_val, 8'h00);
      idle(2);
      bus_rd(ICR); check("t1_period", rd_val, 8'h01);

      // one-shot with interrupt enabled
      do_reset();
      bus_wr(ICR, 8'h81); bus_wr(0, 2); bus_wr(1, 0); bus_wr(3, 8'h09);
      idle(3); check("t2_irq_pre", irq_n, 1'b1);
      idle(1); check("t2_irq", irq_n, 1'b0);
      bus_rd(3); check("t2_ctrl", rd_val, 8'h08);
      bus_rd(0); check("t2_cnt", rd_val, 8'h02);
      bus_rd(ICR); check("t2_icr", rd_val, 8'h81);
      check("t2_irq_held", irq_n, 1'b0);
      idle(1); check("t2_irq_rel", irq_n, 1'b1);

      // cascade: ch1 counts ch0 underflows
      do_reset();
      bus_wr(0, 1); bus_wr(1, 0); bus_wr(4, 2); bus_wr(5, 0);
      bus_wr(7, 8'h41); bus_wr(3, 8'h01);
      for (int j = 1; j <= 12; j++) begin
         bus_rd(ICR);
         check($sformatf("t3_casc_%0d", j), rd_val,
               ((j % 2 == 0) ? 1 : 0) | ((j % 6 == 0) ? 2 : 0));
      end

      // snapshot of upper byte survives further counting
      do_reset();
      bus_wr(0, 8'h00); bus_wr(1, 8'h01); bus_wr(3, 8'h11);
      bus_rd(0); check("t4_lo", rd_val, 8'h00);
      idle(4);
      bus_rd(1); check("t4_snap_hi", rd_val, 8'h01);
      bus_rd(0); check("t4_live_lo", rd_val, 8'hFA);
      bus_rd(1); check("t4_new_hi", rd_val, 8'h00);

      // toggle output
      do_reset();
      bus_wr(0, 1); bus_wr(1, 0); bus_wr(3, 8'h07);
      check("t5_start", tmr_out[0], 1'b1);
      for (int j = 1; j <= 6; j++) begin
         idle(1);
         check($sformatf("t5_tog_%0d", j), tmr_out[0], ((j / 2) % 2 == 0) ? 1 : 0);
      end
      bus_wr(3, 8'h06); check("t5_stopped", tmr_out[0], 1'b0);
      bus_wr(3, 8'h07); check("t5_force", tmr_out[0], 1'b1);

      // ICR read racing an underflow, then reset mid-count
      do_reset();
      bus_wr(ICR, 8'h81); bus_wr(0, 3); bus_wr(1, 0); bus_wr(3, 8'h07);
      idle(6);
      bus_rd(ICR); check("t6_icr1", rd_val, 8'h81);
      idle(1); check("t6_irq_hi", irq_n, 1'b1);
      bus_rd(ICR); check("t6_race", rd_val, 8'h81);
      check("t6_irq_again", irq_n, 1'b0);
      idle(4);
      check("t6_pre_tmr", tmr_out[0], 1'b0);
      check("t6_pre_irq", irq_n, 1'b0);
      #2 res = 1'b1;
      #1;
      check("t6_rst_tmr", tmr_out, 2'b11);
      check("t6_rst_irq", irq_n, 1'b1);
      check("t6_rst_db", db_out, 8'h00);
      @(negedge clk);
      res = 1'b0;
      model_reset();
      bus_rd(0); check("t6_rst_cnt", rd_val, 8'h00);
      bus_rd(ICR); check("t6_rst_icr", rd_val, 8'h00);

      // randomized traffic against the model
      do_reset();
      repeat (600) begin
         int op, a, d, k;
         bit r;
         cnt_drive = 1'($urandom_range(0, 1));
         op = $urandom_range(0, 9);
         if (op < 4) begin
            idle(1);
         end else begin
            a = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8);
            r = 1'($urandom_range(0, 1));
            k = a % 4;
            if (a < 8 && k == 0)      d = $urandom_range(0, 6);
            else if (a < 8 && k == 1) d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : 0;
            else                      d = $urandom_range(0, 255);
            cyc(1, r, a, d);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
